// File: rtl/display_scan_if.sv
// Scan-bus interface between a multiplexed seven-segment driver and the
// receive-side decoder that turns the scan back into a six-digit frame.
interface display_scan_if;
  logic [5:0] an;
  logic [7:0] sseg;
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] hex4;
  logic [3:0] hex5;
  logic [5:0] dp;
  logic [5:0] blank;
  logic       frame_valid;
  logic       pattern_err;

  modport master (
    output an, sseg,
    input  hex0, hex1, hex2, hex3, hex4, hex5, dp, blank, frame_valid, pattern_err
  );

  modport slave (
    input  an, sseg,
    output hex0, hex1, hex2, hex3, hex4, hex5, dp, blank, frame_valid, pattern_err
  );
endinterface

// File: rtl/display_scan_decoder.sv
// Samples a six-digit multiplexed seven-segment scan, waits for each digit
// window to settle, decodes it and publishes complete frames atomically.
module display_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  scan
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } entry_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
    logic       blank;
  } decode_t;

  localparam logic [7:0] SETTLE_C    = 8'(SETTLE);
  localparam logic [7:0] SETTLE_LAST = SETTLE_C - 8'd1;

  // Active-low a..g codes; all-off is a legal blank digit reading as 0.
  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t d;
    d = '{valid: 1'b1, value: 4'h0, blank: 1'b0};
    case (seg)
      7'h40: d.value = 4'h0;
      7'h79: d.value = 4'h1;
      7'h24: d.value = 4'h2;
      7'h30: d.value = 4'h3;
      7'h19: d.value = 4'h4;
      7'h12: d.value = 4'h5;
      7'h02: d.value = 4'h6;
      7'h78: d.value = 4'h7;
      7'h00: d.value = 4'h8;
      7'h10: d.value = 4'h9;
      7'h08: d.value = 4'hA;
      7'h03: d.value = 4'hB;
      7'h46: d.value = 4'hC;
      7'h21: d.value = 4'hD;
      7'h06: d.value = 4'hE;
      7'h0E: d.value = 4'hF;
      7'h7F: d.blank = 1'b1;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  state_t            r_state;
  logic [13:0]       r_sample;
  logic [7:0]        r_cnt;
  logic [5:0]        r_seen;
  entry_t [5:0]      r_stage;
  entry_t [5:0]      r_pub;
  logic              r_frame_valid;
  logic              r_pattern_err;

  logic [13:0]       w_in;
  logic [5:0]        w_sel;
  logic              w_onehot;
  logic              w_changed;
  logic [2:0]        w_idx;
  decode_t           w_dec;
  entry_t            w_entry;
  logic [5:0]        w_seen_set;
  logic [5:0]        w_dp;
  logic [5:0]        w_blank;

  assign w_in       = {scan.an, scan.sseg};
  assign w_sel      = ~scan.an;
  assign w_onehot   = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);
  assign w_changed  = (w_in != r_sample);
  assign w_dec      = decode_seg(scan.sseg[6:0]);
  assign w_entry    = '{value: w_dec.value, dp: ~scan.sseg[7], blank: w_dec.blank};
  assign w_seen_set = r_seen | (6'b1 << w_idx);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_sample      <= '1;
      r_cnt         <= 8'd0;
      r_seen        <= 6'd0;
      // NOTE: the staging store is six small registers, so it is reset like any other state.
      r_stage       <= '0;
      r_pub         <= '0;
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
    end else begin
      r_sample      <= w_in;
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
      if (!w_onehot) begin
        r_state <= S_IDLE;
        r_cnt   <= 8'd0;
      end else if (w_changed || r_state == S_IDLE) begin
        r_state <= S_SETTLE;
        r_cnt   <= 8'd0;
      end else if (r_state == S_SETTLE) begin
        if (r_cnt == SETTLE_LAST) begin
          r_state <= S_DONE;
          r_cnt   <= SETTLE_C;
          if (w_dec.valid) begin
            r_stage[w_idx] <= w_entry;
            if (w_seen_set == 6'h3F) begin
              // Sixth digit publishes in the same edge, merging the fresh capture.
              for (int j = 0; j < 6; j++) begin
                r_pub[j] <= (3'(j) == w_idx) ? w_entry : r_stage[j];
              end
              r_seen        <= 6'd0;
              r_frame_valid <= 1'b1;
            end else begin
              r_seen <= w_seen_set;
            end
          end else begin
            r_seen[w_idx] <= 1'b0;
            r_pattern_err <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_dp    = 6'd0;
    w_blank = 6'd0;
    for (int i = 0; i < 6; i++) begin
      w_dp[i]    = r_pub[i].dp;
      w_blank[i] = r_pub[i].blank;
    end
  end

  assign scan.hex0        = r_pub[0].value;
  assign scan.hex1        = r_pub[1].value;
  assign scan.hex2        = r_pub[2].value;
  assign scan.hex3        = r_pub[3].value;
  assign scan.hex4        = r_pub[4].value;
  assign scan.hex5        = r_pub[5].value;
  assign scan.dp          = w_dp;
  assign scan.blank       = w_blank;
  assign scan.frame_valid = r_frame_valid;
  assign scan.pattern_err = r_pattern_err;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Self-checking bench for display_scan_decoder: directed scan scenarios plus
// random windows, compared every cycle against a run-length reference model.
module tb_display_scan_decoder;

  localparam int SETTLE = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_fv;
  int   n_pe;

  display_scan_if bus ();

  display_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scan  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: a window is captured when the same one-hot input has been
  // present at SETTLE+1 consecutive rising edges.
  logic [6:0]  codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [13:0] m_prev;
  int          m_run;
  logic [3:0]  m_val   [6];
  logic        m_dp    [6];
  logic        m_blank [6];
  logic [5:0]  m_seen;
  logic [3:0]  e_hex   [6];
  logic [5:0]  e_dp;
  logic [5:0]  e_blank;
  logic        e_fv;
  logic        e_pe;

  task automatic model_reset();
    m_prev = '1;
    m_run  = 0;
    m_seen = 6'd0;
    for (int i = 0; i < 6; i++) begin
      m_val[i] = 4'd0; m_dp[i] = 1'b0; m_blank[i] = 1'b0; e_hex[i] = 4'd0;
    end
    e_dp = 6'd0; e_blank = 6'd0; e_fv = 1'b0; e_pe = 1'b0;
  endtask

  task automatic model_edge(input logic [5:0] a, input logic [7:0] s);
    int  idx;
    int  val;
    logic blk;
    e_fv = 1'b0;
    e_pe = 1'b0;
    if ({a, s} == m_prev) m_run++;
    else m_run = 1;
    m_prev = {a, s};
    if ($countones(~a) == 1 && m_run == SETTLE + 1) begin
      idx = 0;
      for (int i = 0; i < 6; i++) if (!a[i]) idx = i;
      val = -1;
      blk = 1'b0;
      for (int c = 0; c < 16; c++) if (codes[c] == s[6:0]) val = c;
      if (s[6:0] == 7'h7F) begin val = 0; blk = 1'b1; end
      if (val >= 0) begin
        m_val[idx] = 4'(val); m_dp[idx] = ~s[7]; m_blank[idx] = blk;
        m_seen[idx] = 1'b1;
        if (m_seen == 6'h3F) begin
          for (int i = 0; i < 6; i++) begin
            e_hex[i] = m_val[i]; e_dp[i] = m_dp[i]; e_blank[i] = m_blank[i];
          end
          m_seen = 6'd0;
          e_fv   = 1'b1;
        end
      end else begin
        m_seen[idx] = 1'b0;
        e_pe = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
    check("pattern_err", 32'(bus.pattern_err), 32'(e_pe));
    check("hex", 32'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}),
          32'({e_hex[5], e_hex[4], e_hex[3], e_hex[2], e_hex[1], e_hex[0]}));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("blank", 32'(bus.blank), 32'(e_blank));
    n_fv += int'(bus.frame_valid);
    n_pe += int'(bus.pattern_err);
  endtask

  task automatic step(input logic [5:0] a, input logic [7:0] s);
    bus.an   = a;
    bus.sseg = s;
    @(posedge clk);
    if (rst_n) model_edge(a, s);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [5:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s);
  endtask

  task automatic show(input int d, input logic [7:0] s, input int n);
    hold(6'(~(6'b1 << d)), s, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  logic [7:0] digit_code [6] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};

  initial begin
    int fv0;
    int pe0;
    checks = 0; errors = 0; n_fv = 0; n_pe = 0;
    bus.an = '1; bus.sseg = '1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_hex", 32'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'd0);
    rst_n = 1'b1;
    hold(6'h3F, 8'hFF, 3);

    // Six-digit sweep.
    fv0 = n_fv;
    for (int d = 0; d < 6; d++) show(d, digit_code[d], 6);
    check("sweep_fv_count", 32'(n_fv - fv0), 32'd1);
    check("sweep_hex", 32'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'h543210);
    check("sweep_dp", 32'(bus.dp), 32'd0);
    check("sweep_blank", 32'(bus.blank), 32'd0);

    // Glitch window: too-short digit 2 windows never capture.
    fv0 = n_fv;
    show(0, 8'hC0, 6); show(1, 8'hF9, 6); show(2, 8'hA4, 3);
    show(1, 8'hF9, 6); show(3, 8'hB0, 6); show(4, 8'h99, 6); show(5, 8'h92, 6);
    show(2, 8'hA4, SETTLE); show(4, 8'h99, 6);
    check("glitch_withheld", 32'(n_fv - fv0), 32'd0);
    show(2, 8'hA4, SETTLE + 1);
    check("glitch_released", 32'(n_fv - fv0), 32'd1);

    // Bad pattern on digit 2.
    fv0 = n_fv; pe0 = n_pe;
    show(0, 8'hC0, 6); show(1, 8'hF9, 6); show(2, 8'hFE, 6);
    show(3, 8'hB0, 6); show(4, 8'h99, 6); show(5, 8'h92, 6);
    check("bad_pattern_pulse", 32'(n_pe - pe0), 32'd1);
    check("bad_pattern_no_frame", 32'(n_fv - fv0), 32'd0);
    show(2, 8'hA4, 6);
    check("bad_pattern_recovered", 32'(n_fv - fv0), 32'd1);

    // Two anodes active: ignored, seen preserved.
    fv0 = n_fv; pe0 = n_pe;
    show(0, 8'hC0, 6); show(1, 8'hF9, 6);
    hold(6'h3C, 8'hC0, 20);
    check("illegal_no_pulses", 32'((n_fv - fv0) + (n_pe - pe0)), 32'd0);
    for (int d = 2; d < 6; d++) show(d, digit_code[d], 6);
    check("illegal_seen_kept", 32'(n_fv - fv0), 32'd1);

    // Decimal point and blank digit.
    show(0, 8'h40, 6);
    for (int d = 1; d < 5; d++) show(d, digit_code[d], 6);
    show(5, 8'hFF, 6);
    check("dpblank_hex", 32'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 32'h043210);
    check("dpblank_dp", 32'(bus.dp), 32'h01);
    check("dpblank_blank", 32'(bus.blank), 32'h20);

    // Reset mid-frame discards staging.
    for (int d = 0; d < 3; d++) show(d, digit_code[d], 6);
    do_reset();
    check("reset_mid_dp", 32'(bus.dp), 32'd0);
    fv0 = n_fv;
    for (int d = 3; d < 6; d++) show(d, digit_code[d], 6);
    check("reset_no_frame", 32'(n_fv - fv0), 32'd0);
    for (int d = 0; d < 6; d++) show(d, digit_code[d], 6);
    check("reset_full_frame", 32'(n_fv - fv0), 32'd1);

    // Random windows.
    for (int w = 0; w < 300; w++) begin
      logic [5:0] a;
      logic [7:0] s;
      int kind;
      a = 6'(~(6'b1 << $urandom_range(0, 5)));
      if ($urandom_range(0, 9) == 0) a = 6'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       s[6:0] = codes[$urandom_range(0, 15)];
      else if (kind == 7) s[6:0] = 7'h7F;
      else                s[6:0] = 7'($urandom);
      s[7] = 1'($urandom);
      hold(a, s, int'($urandom_range(1, 8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_decoder.md
# display_scan_decoder

Receive-side counterpart of the six-digit multiplexed seven-segment driver. It samples the scanned anode-select and segment buses, waits for each digit window to settle, and decodes the segment pattern back to a 4-bit hex value. It assembles a full six-digit frame and publishes it atomically. It sits on the scan bus in self-checking benches and board-level loopback, and turns the driver's `an`/`sseg` outputs back into `hex0..hex5`.

## Interface
- `SETTLE`, default 4: consecutive identical samples required before a digit window is captured (legal range 1..255).
- `clk`  in  1  system clock; all logic is synchronous to its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `an`  in  6  digit select, active-low; bit i selects digit i.
- `sseg`  in  8  segments, active-low; bit 0..6 = a..g, bit 7 = dp.
- `hex0`..`hex5`  out  4 each  decoded digit values of the last complete frame.
- `dp`  out  6  decimal-point state per digit of the last frame (1 = lit).
- `blank`  out  6  per digit, 1 = all segments a..g were off in the last frame.
- `frame_valid`  out  1  one-cycle pulse when the published frame updates.
- `pattern_err`  out  1  one-cycle pulse when a settled window has an undecodable pattern.

## Operation
- The inputs are in the `clk` domain. No synchronizer is used.
- Sample register: `{an,sseg}` is registered every edge.
- Stability counter:
  - Cleared to 0 when the current input differs from the sampled value.
  - Otherwise increments, saturating at `SETTLE`.
- Window valid only if `an` has exactly one zero bit. Zero or multiple active anodes: counter held at 0, FSM to IDLE, nothing captured.
- FSM:
  - **IDLE**: no valid window. Moves to SETTLE when a one-hot `an` appears.
  - **SETTLE**: counting. On reaching `SETTLE` consecutive identical samples, capture and move to DONE. Any input change returns to SETTLE with count 0, or to IDLE if `an` is no longer one-hot.
  - **DONE**: window already captured, so there is no re-capture. Any input change moves to SETTLE or IDLE.
- Decode of `sseg[6:0]`, active-low codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - 7F = blank: value 0, blank bit = 1.
  - dp = ~`sseg[7]`. dp is independent of the a..g decode.
- Capture of a valid code writes the staging entry for digit i (value, dp, blank) and sets `seen[i]`. A later window for the same digit overwrites its entry (latest wins).
- Capture of an invalid code: `pattern_err` pulses, `seen[i]` is cleared, and the staging entry is unchanged.
- When the capture makes `seen` all ones:
  - All six staging entries are copied to `hex*`/`dp`/`blank` in the same edge.
  - `frame_valid` pulses.
  - `seen` is cleared.
- Published outputs change only on that edge.

## Timing
- Reset values: `hex0..hex5`=0, `dp`=0, `blank`=0, `frame_valid`=0, `pattern_err`=0, `seen`=0, staging=0, counter=0, FSM=IDLE, sample register=all ones.
- Capture latency: the input is applied before edge k and held. The capture occurs on edge k+`SETTLE`. `frame_valid`/`pattern_err` are high during the cycle following that edge, for exactly one cycle.
- A window held `SETTLE` cycles or fewer produces no capture. It must be held ≥ `SETTLE`+1 edges.
- Back-to-back windows need no gap. A change on the edge after a capture starts a new count.
- The sixth-digit capture and the publish happen on the same edge. No extra latency.
- Asynchronous reset mid-frame discards all staging and `seen` immediately. A full new frame of six captures is needed before the next `frame_valid`.

## Test plan
- Six-digit sweep, `SETTLE`=4: each window held 6 cycles, in order:

  | `an` | `sseg` |
  |---|---|
  | 3E | C0 |
  | 3D | F9 |
  | 3B | A4 |
  | 37 | B0 |
  | 2F | 99 |
  | 1F | 92 |

  Expect one `frame_valid` pulse, `hex0..5`=0,1,2,3,4,5, `dp`=0, `blank`=0.
- Glitch window: `an`=3B held 3 cycles, then 3D → no capture of digit 2. `frame_valid` is withheld until digit 2 is shown for ≥5 cycles.
- Bad pattern: digit 2 with `sseg`=FE → `pattern_err` pulses once. The frame completes only after digit 2 is reshown with A4.
- Illegal select: `an`=3C (two anodes active) held 20 cycles → no capture, no pulses, `seen` unchanged.
- dp/blank: digit 0 `sseg`=40, digit 5 `sseg`=FF, others valid → `hex0`=0, `dp`[0]=1, `blank`[5]=1, `hex5`=0.
- Reset mid-frame: capture 3 digits, pulse `rst_n` low for 2 cycles → all outputs 0. The next `frame_valid` occurs only after all six digits are recaptured.
